// File: rtl/dvp_gen_pkg.sv
// dvp_gen_pkg: pattern codes, FSM states and colour-bar helper shared by the DVP sensor generator
package dvp_gen_pkg;
  localparam logic [1:0] PAT_TOGGLE = 2'd0;
  localparam logic [1:0] PAT_RAMP = 2'd1;
  localparam logic [1:0] PAT_BARS = 2'd2;
  localparam logic [1:0] PAT_FCNT = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  // Eight equal colour bars across the active width; the divisor is a constant at elaboration.
  function automatic logic [2:0] bar_index(input int unsigned px, input int unsigned h_active);
    return 3'((px * 8) / h_active);
  endfunction
endpackage

// File: rtl/dvp_timing_cnt.sv
// dvp_timing_cnt: byte/pixel/line raster counters with frame-end, vsync and active-area decode
// Ports: clk, rst (sync active-high), run (advance counters, else hold at 0);
//   px pixel index, b byte within pixel, vcnt line index; first (at origin), frame_end (last byte while
//   running), vsync/href combinational decode of the current counter position.
module dvp_timing_cnt #(
  parameter int BPP = 2,
  parameter int H_ACTIVE = 1280,
  parameter int H_TOTAL = 1648,
  parameter int V_ACTIVE = 720,
  parameter int V_TOTAL = 750,
  parameter int V_SYNC_LEN = 4,
  parameter int V_ACT_START = 9,
  localparam int HW = $clog2(H_TOTAL + 1),
  localparam int BW = BPP > 1 ? $clog2(BPP) : 1,
  localparam int VW = $clog2(V_TOTAL + 1)
) (
  input logic clk,
  input logic rst,
  input logic run,
  output logic [HW-1:0] px,
  output logic [BW-1:0] b,
  output logic [VW-1:0] vcnt,
  output logic first,
  output logic frame_end,
  output logic vsync,
  output logic href
);
  logic b_last, h_last, v_last;
  // hcnt is kept split as px*BPP+b so no divider is needed for px and b.
  always_comb begin
    b_last = b == BW'(BPP - 1);
    h_last = b_last && px == HW'(H_TOTAL - 1);
    v_last = vcnt == VW'(V_TOTAL - 1);
    first = px == '0 && b == '0 && vcnt == '0;
    frame_end = run && h_last && v_last;
    vsync = vcnt < VW'(V_SYNC_LEN);
    href = vcnt >= VW'(V_ACT_START) && vcnt < VW'(V_ACT_START + V_ACTIVE) && px < HW'(H_ACTIVE);
  end
  always_ff @(posedge clk)
    if (rst || !run) begin
      px <= '0;
      b <= '0;
      vcnt <= '0;
    end else begin
      b <= b_last ? '0 : b + BW'(1);
      px <= h_last ? '0 : b_last ? px + HW'(1) : px;
      vcnt <= !h_last ? vcnt : v_last ? '0 : vcnt + VW'(1);
    end
endmodule

// File: rtl/dvp_sensor_gen.sv
// dvp_sensor_gen: parametrised DVP camera-sensor source with test patterns and frame control
// Ports: cmos_xclk_i clock, rst_i sync active-high reset, enable_i run request (frames start on boundaries),
//   pattern_sel_i 0 toggle/1 ramp/2 colour bars/3 frame-count fill; cmos_pclk_o/vsync/href/data DVP bus,
//   frame_start_o first-vsync pulse, frame_cnt_o completed frames, checksum_o/checksum_vld_o per-frame sum.
// Define DVP_CHECKSUM_EN to build the per-frame checksum; otherwise checksum outputs are tied 0.
module dvp_sensor_gen
  import dvp_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BPP = 2,
  parameter int H_ACTIVE = 1280,
  parameter int H_TOTAL = 1648,
  parameter int V_ACTIVE = 720,
  parameter int V_TOTAL = 750,
  parameter int V_SYNC_LEN = 4,
  parameter int V_ACT_START = 9
) (
  input logic cmos_xclk_i,
  input logic rst_i,
  input logic enable_i,
  input logic [1:0] pattern_sel_i,
  output logic cmos_pclk_o,
  output logic cmos_vsync_o,
  output logic cmos_href_o,
  output logic [DATA_W-1:0] cmos_data_o,
  output logic frame_start_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] checksum_o,
  output logic checksum_vld_o
);
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int BW = BPP > 1 ? $clog2(BPP) : 1;
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [DATA_W-1:0] P55 = DATA_W'({((DATA_W + 1) / 2){2'b01}});
  state_t state;
  logic run, first, frame_end, vsync, href, tog, tog_q;
  logic [1:0] pat, pat_q;
  logic [HW-1:0] px;
  logic [BW-1:0] b;
  logic [VW-1:0] vcnt;
  logic [DATA_W-1:0] ramp, bars, data_nxt;
  assign cmos_pclk_o = cmos_xclk_i;
  assign run = state != IDLE;
  dvp_timing_cnt #(
    .BPP(BPP),
    .H_ACTIVE(H_ACTIVE),
    .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE),
    .V_TOTAL(V_TOTAL),
    .V_SYNC_LEN(V_SYNC_LEN),
    .V_ACT_START(V_ACT_START)
  ) u_cnt (
    .clk(cmos_xclk_i),
    .rst(rst_i),
    .run(run),
    .px(px),
    .b(b),
    .vcnt(vcnt),
    .first(first),
    .frame_end(frame_end),
    .vsync(vsync),
    .href(href)
  );
  // At the frame origin the live selector and a fresh toggle phase apply; otherwise the frame's latched copies.
  always_comb begin
    pat = first ? pattern_sel_i : pat_q;
    tog = first ? 1'b0 : tog_q;
    ramp = DATA_W'(px) + DATA_W'(vcnt - VW'(V_ACT_START));
    bars = {bar_index(32'(px), H_ACTIVE), (DATA_W - 3)'(b)};
    data_nxt = !href ? '0 : pat == PAT_TOGGLE ? (tog ? ~P55 : P55) : pat == PAT_RAMP ? ramp :
               pat == PAT_BARS ? bars : DATA_W'(frame_cnt_o);
  end
  // Leaving RUN without a frame end parks in DRAIN so the current frame always completes.
  always_ff @(posedge cmos_xclk_i)
    if (rst_i) begin
      state <= IDLE;
      pat_q <= PAT_TOGGLE;
      tog_q <= 1'b0;
      cmos_vsync_o <= 1'b0;
      cmos_href_o <= 1'b0;
      cmos_data_o <= '0;
      frame_start_o <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state <= enable_i ? RUN : (!run || frame_end) ? IDLE : DRAIN;
      pat_q <= run ? pat : pat_q;
      tog_q <= run ? tog ^ href : tog_q;
      cmos_vsync_o <= run && vsync;
      cmos_href_o <= run && href;
      cmos_data_o <= run ? data_nxt : '0;
      frame_start_o <= run && first;
      frame_cnt_o <= frame_end ? frame_cnt_o + 16'd1 : frame_cnt_o;
    end
`ifdef DVP_CHECKSUM_EN
  logic [15:0] acc;
  // The sum includes the byte decoded in the frame-end cycle so it lines up with the frame_cnt update.
  always_ff @(posedge cmos_xclk_i)
    if (rst_i) begin
      acc <= '0;
      checksum_o <= '0;
      checksum_vld_o <= 1'b0;
    end else begin
      acc <= !run ? acc : first ? 16'(data_nxt) : acc + 16'(data_nxt);
      checksum_o <= frame_end ? acc + 16'(data_nxt) : checksum_o;
      checksum_vld_o <= frame_end;
    end
`else
  assign checksum_o = '0;
  assign checksum_vld_o = 1'b0;
`endif
endmodule

// File: tb/tb_dvp_sensor_gen.sv
// tb_dvp_sensor_gen: scoreboard bench for dvp_sensor_gen on two small rasters
module tb_dvp_sensor_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic en_b = 1'b0;
  logic [1:0] pat = 2'd0;
  logic pclk, vs, hr, fs, ckv;
  logic [7:0] d;
  logic [15:0] fc, ck;
  logic pclk_b, vs_b, hr_b, fs_b, ckv_b;
  logic [7:0] d_b;
  logic [15:0] fc_b, ck_b;
  int n_cmp = 0;
  int n_bad = 0;
  int vs_len = 0;
  logic [15:0] sum = '0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [15:0] q_fc[$];
  logic [15:0] q_ck[$];
  logic [7:0] bar_tab[8] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0};
  always #5 clk = ~clk;
  dvp_sensor_gen #(
    .DATA_W(8), .BPP(2), .H_ACTIVE(4), .H_TOTAL(6), .V_ACTIVE(3), .V_TOTAL(8), .V_SYNC_LEN(2), .V_ACT_START(3)
  ) dut_a (
    .cmos_xclk_i(clk), .rst_i(rst), .enable_i(en), .pattern_sel_i(pat), .cmos_pclk_o(pclk),
    .cmos_vsync_o(vs), .cmos_href_o(hr), .cmos_data_o(d), .frame_start_o(fs), .frame_cnt_o(fc),
    .checksum_o(ck), .checksum_vld_o(ckv)
  );
  dvp_sensor_gen #(
    .DATA_W(8), .BPP(1), .H_ACTIVE(8), .H_TOTAL(10), .V_ACTIVE(2), .V_TOTAL(5), .V_SYNC_LEN(1), .V_ACT_START(2)
  ) dut_b (
    .cmos_xclk_i(clk), .rst_i(rst), .enable_i(en_b), .pattern_sel_i(2'd2), .cmos_pclk_o(pclk_b),
    .cmos_vsync_o(vs_b), .cmos_href_o(hr_b), .cmos_data_o(d_b), .frame_start_o(fs_b), .frame_cnt_o(fc_b),
    .checksum_o(ck_b), .checksum_vld_o(ckv_b)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic unexpected(input string nm, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endtask
  task automatic push_a(input logic [7:0] v);
    q_a.push_back(v);
    sum = sum + 16'(v);
  endtask
  task automatic end_frame_a();
`ifdef DVP_CHECKSUM_EN
    q_ck.push_back(sum);
`endif
    sum = '0;
  endtask
  task automatic wait_fs(input bit sel, input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sel ? fs_b : fs) && k < 400);
    if (!(sel ? fs_b : fs)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no frame_start within 400 cycles", nm);
    end
  endtask
  always @(negedge clk) begin
    if (hr) begin
      if (q_a.size() == 0) unexpected("a_href_byte", d);
      else chk("a_href_byte", d, q_a.pop_front());
    end else chk("a_blank_data", d, 0);
    if (hr_b) begin
      if (q_b.size() == 0) unexpected("b_href_byte", d_b);
      else chk("b_href_byte", d_b, q_b.pop_front());
    end else chk("b_blank_data", d_b, 0);
    if (fs) begin
      if (q_fc.size() == 0) unexpected("a_frame_cnt_at_start", fc);
      else chk("a_frame_cnt_at_start", fc, q_fc.pop_front());
    end
    if (ckv) begin
      if (q_ck.size() == 0) unexpected("a_checksum", ck);
      else chk("a_checksum", ck, q_ck.pop_front());
    end
    if (rst) vs_len = 0;
    else if (vs) vs_len++;
    else if (vs_len != 0) begin
      chk("a_vsync_len", vs_len, 24);
      vs_len = 0;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vsync", vs, 0);
    chk("rst_href", hr, 0);
    chk("rst_data", d, 0);
    chk("rst_frame_start", fs, 0);
    chk("rst_frame_cnt", fc, 0);
    chk("rst_checksum", ck, 0);
    chk("rst_checksum_vld", ckv, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_vsync", vs, 0);
    chk("idle_frame_start", fs, 0);
    chk("b_idle_vsync", vs_b, 0);
    for (int f = 0; f < 5; f++) q_fc.push_back(16'(f));
    fork
      begin
        for (int i = 0; i < 24; i++) push_a(i[0] ? 8'hAA : 8'h55);
        end_frame_a();
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("a_frame_start_latency", fs, 1);
        chk("a_vsync_first", vs, 1);
        pat = 2'd1;
        for (int l = 0; l < 3; l++)
          for (int h = 0; h < 8; h++) push_a(8'(h / 2 + l));
        end_frame_a();
        repeat (94) @(negedge clk);
        chk("a_frame_cnt_before_end", fc, 0);
        @(negedge clk);
        chk("a_frame_cnt_after_96", fc, 1);
        wait_fs(1'b0, "a_frame2_start");
        repeat (50) @(negedge clk);
        pat = 2'd3;
        for (int i = 0; i < 24; i++) push_a(8'h02);
        end_frame_a();
        wait_fs(1'b0, "a_frame3_start");
        repeat (48) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 200 && fc != 16'd3; k++) @(negedge clk);
        chk("a_drain_frame_cnt", fc, 3);
        repeat (20) @(negedge clk);
        chk("a_idle_vsync", vs, 0);
        chk("a_idle_href", hr, 0);
        chk("a_idle_frame_cnt", fc, 3);
`ifndef DVP_CHECKSUM_EN
        chk("a_checksum_tied", ck, 0);
`endif
        for (int i = 0; i < 24; i++) push_a(8'h03);
        end_frame_a();
        en = 1'b1;
        wait_fs(1'b0, "a_frame4_start");
        wait_fs(1'b0, "a_frame5_start");
        repeat (13) @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_midrst_frame_cnt", fc, 0);
        chk("a_midrst_vsync", vs, 0);
        chk("a_midrst_checksum", ck, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("a_after_rst_frame_cnt", fc, 0);
        chk("a_after_rst_vsync", vs, 0);
      end
      begin
        for (int l = 0; l < 2; l++)
          for (int p = 0; p < 8; p++) q_b.push_back(bar_tab[p]);
        en_b = 1'b1;
        wait_fs(1'b1, "b_frame1_start");
        en_b = 1'b0;
        for (int k = 0; k < 200 && fc_b != 16'd1; k++) @(negedge clk);
        chk("b_frame_cnt", fc_b, 1);
        repeat (10) @(negedge clk);
        chk("b_idle_after_drain", vs_b, 0);
      end
    join
    chk("a_bytes_all_seen", q_a.size(), 0);
    chk("b_bytes_all_seen", q_b.size(), 0);
    chk("a_frame_starts_all_seen", q_fc.size(), 0);
`ifdef DVP_CHECKSUM_EN
    chk("a_checksums_all_seen", q_ck.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dvp_sensor_gen.md
Name: dvp_sensor_gen

Overview:
Parametrised, synthesisable DVP camera-sensor source, successor to the fixed 720p sensor model. Produces vsync, href and byte data on the pixel clock with configurable raster, bytes per pixel, selectable test patterns and frame control. Drives the capture front-end in simulation and on hardware bring-up when no real sensor is fitted.

Parameters:
DATA_W, 8, data bus width in bits.
BPP, 2, bytes per pixel (1..4).
H_ACTIVE, 1280, active pixels per line.
H_TOTAL, 1648, total pixels per line incl. blanking (> H_ACTIVE).
V_ACTIVE, 720, active lines per frame.
V_TOTAL, 750, total lines per frame.
V_SYNC_LEN, 4, lines with vsync high, starting at line 0.
V_ACT_START, 9, first active line (>= V_SYNC_LEN; V_ACT_START+V_ACTIVE <= V_TOTAL).

Ports:
cmos_xclk_i  in  1  pixel clock; output timing reference.
rst_i  in  1  synchronous, active-high reset.
enable_i  in  1  run request; frames start only on frame boundary.
pattern_sel_i  in  2  0 toggle 0x55/0xAA, 1 ramp, 2 colour bars, 3 frame-count fill.
cmos_pclk_o  out  1  equals cmos_xclk_i.
cmos_vsync_o  out  1  frame sync, active high.
cmos_href_o  out  1  line valid.
cmos_data_o  out  DATA_W  pixel byte stream.
frame_start_o  out  1  one-cycle pulse coincident with first vsync-high cycle.
frame_cnt_o  out  16  completed frames, wraps 0xFFFF->0.
checksum_o  out  16  per-frame byte sum (optional feature).
checksum_vld_o  out  1  one-cycle pulse when checksum_o updates.

Behaviour:
- Reset: all outputs 0, counters 0, FSM IDLE, pattern register 0.
- FSM IDLE -> RUN when enable_i=1 (counters start at hcnt=vcnt=0 next cycle). RUN -> DRAIN when enable_i=0; DRAIN -> RUN if enable_i returns before frame end. At frame end (hcnt=HB_TOTAL-1, vcnt=V_TOTAL-1): RUN stays RUN; DRAIN -> IDLE. IDLE holds counters at 0, all outputs 0.
- hcnt counts bytes 0..HB_TOTAL-1, HB_TOTAL=H_TOTAL*BPP; vcnt increments on hcnt wrap, wraps at V_TOTAL-1.
- All outputs registered: values at cycle t+1 decoded from counters at t (latency 1).
- vsync = (vcnt < V_SYNC_LEN). href = (V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE) and (hcnt < H_ACTIVE*BPP).
- px = hcnt/BPP, b = hcnt%BPP, line = vcnt-V_ACT_START.
- pattern_sel_i sampled only at hcnt=vcnt=0; mid-frame changes ignored.
- Pattern 0: data starts 0x55 each frame, inverts after every href byte. Pattern 1: data = (px+line) mod 2^DATA_W. Pattern 2: bar = px*8/H_ACTIVE; data = bar in top 3 bits, b in low bits, rest 0. Pattern 3: data = frame_cnt_o low DATA_W bits.
- data = 0 whenever href = 0 (except pattern 0 hold is internal only).
- frame_cnt_o increments at each completed frame end, including the final DRAIN frame.
- Reset mid-frame: immediate return to IDLE, counters 0, no frame_cnt increment.

Optional Feature:
DVP_CHECKSUM_EN: defined -> 16-bit modular sum of all href bytes accumulated per frame, cleared at frame start, latched into checksum_o with checksum_vld_o pulse the cycle after frame end. Undefined -> checksum_o and checksum_vld_o tied 0, no accumulator logic.

Decomposition:
Package dvp_gen_pkg: pattern code constants (PAT_TOGGLE, PAT_RAMP, PAT_BARS, PAT_FCNT), FSM state enum (IDLE, RUN, DRAIN), bar-width helper function. One sub-module natural: dvp_timing_cnt (hcnt/vcnt counters, frame-end/active decode); pattern mux and FSM stay in top.

Test Plan:
Small raster H_ACTIVE=4, H_TOTAL=6, V_ACTIVE=3, V_TOTAL=8, V_SYNC_LEN=2, V_ACT_START=3, BPP=2, pattern 0, enable high -> vsync high 24 cycles, each active line 8 href bytes 55,AA,55,...; 24 bytes per frame; frame_cnt_o=1 after 96 cycles.
Same raster, pattern 1 -> line 0 bytes 00,00,01,01,02,02,03,03; line 2 bytes 02,02,03,03,04,04,05,05.
Pattern 2, H_ACTIVE=8, BPP=1 -> bytes 00,20,40,60,80,A0,C0,E0 each line.
enable_i dropped at line 4 of frame 2 -> frame 2 completes, frame_cnt_o=2, then outputs stay 0; re-enable -> frame_start_o pulse, frame_cnt_o=3 after next frame end.
pattern_sel_i changed 1->3 mid-frame -> current frame keeps ramp; next frame all active bytes = current frame_cnt_o.
DVP_CHECKSUM_EN, pattern 0, small raster -> checksum_o = 12*0x55+12*0xAA = 0x0BF4, checksum_vld_o single pulse per frame; rst_i mid-frame -> no pulse, frame_cnt_o=0.
